// File: rtl/vector_component_alu.sv
// Four-lane, 16-bit vector ALU with one shared datapath that processes one lane per cycle.
// It supports ADD, SUB, low-16 MUL and a DOT accumulate, with valid/ready on both sides.
module vector_component_alu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_opcode,
    input  logic [15:0] in_a0,
    input  logic [15:0] in_a1,
    input  logic [15:0] in_a2,
    input  logic [15:0] in_a3,
    input  logic [15:0] in_b0,
    input  logic [15:0] in_b1,
    input  logic [15:0] in_b2,
    input  logic [15:0] in_b3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic        out_busy
);

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDot = 2'b11;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      acc_q, acc_d;
    logic [1:0]       op_q, op_d;
    logic [3:0][15:0] a_q, a_d;
    logic [3:0][15:0] b_q, b_d;
    logic [3:0][15:0] result_q, result_d;

    logic [15:0] a_sel, b_sel, mul_lo, dot_sum, lane_val;

    // Shared lane datapath; the low 16 bits of a 16x16 product need only a 16-bit multiply.
    always_comb begin
        a_sel   = a_q[idx_q];
        b_sel   = b_q[idx_q];
        mul_lo  = a_sel * b_sel;
        dot_sum = acc_q + mul_lo;
        lane_val = '0;
        unique case (op_q)
            OpAdd: lane_val = a_sel + b_sel;
            OpSub: lane_val = a_sel - b_sel;
            OpMul: lane_val = mul_lo;
            OpDot: lane_val = dot_sum;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = in_opcode;
                    a_d     = {in_a3, in_a2, in_a1, in_a0};
                    b_d     = {in_b3, in_b2, in_b1, in_b0};
                    idx_d   = 2'd0;
                    acc_d   = 16'd0;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (op_q == OpDot) begin
                    acc_d = dot_sum;
                    if (idx_q == 2'd3) result_d = {48'h0, dot_sum};
                end else begin
                    result_d[idx_q] = lane_val;
                end
                if (idx_q == 2'd3) state_d = StDone;
                else               idx_d   = idx_q + 2'd1;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            acc_q    <= 16'd0;
            op_q     <= 2'd0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign out_busy   = (state_q == StExec) || (state_q == StDone);
    assign out_result = result_q;

endmodule

// File: tb/tb_vector_component_alu.sv
// Directed bench for vector_component_alu: a table of single-op vectors
// plus backpressure and mid-operation reset sequences.
module tb_vector_component_alu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_opcode;
    logic [15:0] in_a0, in_a1, in_a2, in_a3;
    logic [15:0] in_b0, in_b1, in_b2, in_b3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    vector_component_alu dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a0      (in_a0),
        .in_a1      (in_a1),
        .in_a2      (in_a2),
        .in_a3      (in_a3),
        .in_b0      (in_b0),
        .in_b1      (in_b1),
        .in_b2      (in_b2),
        .in_b3      (in_b3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_busy   (out_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        in_opcode = op;
        {in_a3, in_a2, in_a1, in_a0} = a;
        {in_b3, in_b2, in_b1, in_b0} = b;
    endtask

    task automatic scramble();
        in_opcode = 2'($urandom);
        {in_a3, in_a2, in_a1, in_a0} = {$urandom, $urandom};
        {in_b3, in_b2, in_b1, in_b0} = {$urandom, $urandom};
    endtask

    // Presents an op in IDLE, lets it be accepted, then scrambles the inputs.
    task automatic start_op(input string name, input logic [1:0] op,
                            input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        drive(op, a, b);
        in_valid = 1'b1;
        check({name, " in_ready before accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    // Cycles from the accept edge until out_valid is seen; 0 means it never came.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        out_ready = 1'b1;
        start_op(v.name, v.op, v.a, v.b);
        wait_valid(lat);
        check({v.name, " latency"}, 64'(lat), 64'd4);
        check({v.name, " result"}, out_result, v.exp);
        check({v.name, " busy in done"}, 64'(out_busy), 64'd1);
        @(posedge clk);
        #1;
        check({v.name, " valid after xfer"}, 64'(out_valid), 64'd0);
        check({v.name, " ready after xfer"}, 64'(in_ready), 64'd1);
        check({v.name, " result held"}, out_result, v.exp);
    endtask

    initial begin
        int lat;
        vecs[0] = '{"add",      2'b00, 64'h0004_0003_0002_0001, 64'h0010_0010_0010_0010,
                    64'h0014_0013_0012_0011};
        vecs[1] = '{"sub_wrap", 2'b01, 64'h0000_0005_8000_0000, 64'h0001_0005_0001_0001,
                    64'hFFFF_0000_7FFF_FFFF};
        vecs[2] = '{"mul",      2'b10, 64'h0000_FFFF_0003_0100, 64'h0007_0002_0005_0100,
                    64'h0000_FFFE_000F_0000};
        vecs[3] = '{"dot",      2'b11, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005,
                    64'h0000_0000_0000_0046};
        vecs[4] = '{"dot_wrap", 2'b11, 64'h0001_0001_0100_00FF, 64'hFFFE_0002_0100_0101,
                    64'h0000_0000_0000_FFFF};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(2'b00, 64'h0, 64'h0);
        #22;
        check("reset in_ready",  64'(in_ready),  64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_busy",  64'(out_busy),  64'd0);
        check("reset out_result", out_result,    64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Backpressure: result must hold and a competing op must be refused.
        out_ready = 1'b0;
        start_op("bp add", 2'b00, vecs[0].a, vecs[0].b);
        wait_valid(lat);
        check("bp latency", 64'(lat), 64'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(2'b01, vecs[1].a, vecs[1].b);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp out_result", out_result, vecs[0].exp);
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp xfer valid", 64'(out_valid), 64'd0);
        check("bp idle ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        check("bp second accepted", 64'(out_busy), 64'd1);
        wait_valid(lat);
        check("bp second latency", 64'(lat), 64'd4);
        check("bp second result", out_result, vecs[1].exp);
        @(posedge clk);
        #1;

        // Reset two cycles into an ADD, then a DOT must see a clean accumulator.
        start_op("rst add", 2'b00, vecs[0].a, vecs[0].b);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_result", out_result, 64'h0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_busy", 64'(out_busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(vecs[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
